// File: rtl/alarm_ringer.sv
// alarm_ringer: rings a gated buzzer tone (1 s on / 1 s off) on a fresh alarm match, with stop and auto-timeout.
// Define ALARM_SNOOZE_EN to build in the timed snooze path (SNOOZE state, snoozing, snooze_cnt).
module alarm_ringer #(
    parameter int TONE_DIV   = 50000,
    parameter int RING_SEC   = 60,
    parameter int SNOOZE_SEC = 300,
    parameter int MAX_SNOOZE = 3
) (
    input  logic       ck,
    input  logic       reset,
    input  logic       enable,
    input  logic       match,
    input  logic       sec_tick,
    input  logic       stop,
    input  logic       snooze,
    output logic       buzz,
    output logic       ringing,
    output logic       snoozing,
    output logic [1:0] snooze_cnt
);

    localparam int SEC_MAX = (RING_SEC > SNOOZE_SEC) ? RING_SEC : SNOOZE_SEC;
    localparam int SEC_W   = (SEC_MAX > 1) ? $clog2(SEC_MAX) : 1;
    localparam int TONE_W  = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;
    localparam logic [SEC_W-1:0]  RING_LAST = SEC_W'(RING_SEC - 1);
    localparam logic [TONE_W-1:0] TONE_LAST = TONE_W'(TONE_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RING   = 2'd1,
        S_SNOOZE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic                r_stop_q;
    logic                r_match_q;
    logic                w_stop_rise;
    logic                w_match_rise;
    logic [SEC_W-1:0]    r_sec_cnt;
    logic [TONE_W-1:0]   r_tone_cnt;
    logic                r_gate;
    logic                r_tone;
    logic                w_ring_start;
    logic                w_ring_tick;
    logic                w_restart;

    assign w_stop_rise  = stop & ~r_stop_q;
    assign w_match_rise = match & ~r_match_q;

`ifdef ALARM_SNOOZE_EN
    localparam logic [SEC_W-1:0] SNOOZE_LAST = SEC_W'(SNOOZE_SEC - 1);
    localparam logic [1:0]       SNOOZE_MAX  = 2'(MAX_SNOOZE);

    logic       r_snooze_q;
    logic       w_snooze_rise;
    logic       w_snooze_start;
    logic       w_snooze_tick;
    logic       w_rering;
    logic [1:0] r_snooze_cnt;

    assign w_snooze_rise = snooze & ~r_snooze_q;
    assign w_restart     = w_ring_start | w_rering;
    assign snoozing      = (r_state == S_SNOOZE);
    assign snooze_cnt    = r_snooze_cnt;
`else
    logic [2:0] w_unused;

    assign w_unused   = {snooze, 2'(MAX_SNOOZE)};
    assign w_restart  = w_ring_start;
    assign snoozing   = 1'b0;
    assign snooze_cnt = 2'd0;
`endif

    assign ringing = (r_state == S_RING);
    assign buzz    = ringing & r_gate & r_tone;

    always_ff @(posedge ck) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Disable overrides every event; stop beats snooze, snooze beats the second tick.
    always_comb begin
        w_next       = r_state;
        w_ring_start = 1'b0;
        w_ring_tick  = 1'b0;
`ifdef ALARM_SNOOZE_EN
        w_snooze_start = 1'b0;
        w_snooze_tick  = 1'b0;
        w_rering       = 1'b0;
`endif
        if (!enable) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_match_rise) begin
                        w_next       = S_RING;
                        w_ring_start = 1'b1;
                    end
                end
                S_RING: begin
                    if (w_stop_rise) begin
                        w_next = S_DONE;
                    end
`ifdef ALARM_SNOOZE_EN
                    else if (w_snooze_rise) begin
                        if (r_snooze_cnt < SNOOZE_MAX) begin
                            w_next         = S_SNOOZE;
                            w_snooze_start = 1'b1;
                        end else begin
                            w_next = S_DONE;
                        end
                    end
`endif
                    else if (sec_tick) begin
                        if (r_sec_cnt == RING_LAST) w_next = S_DONE;
                        else                        w_ring_tick = 1'b1;
                    end
                end
`ifdef ALARM_SNOOZE_EN
                S_SNOOZE: begin
                    if (w_stop_rise) begin
                        w_next = S_DONE;
                    end else if (sec_tick) begin
                        if (r_sec_cnt == SNOOZE_LAST) begin
                            w_next   = S_RING;
                            w_rering = 1'b1;
                        end else begin
                            w_snooze_tick = 1'b1;
                        end
                    end
                end
`endif
                S_DONE: begin
                    if (!match) w_next = S_IDLE;
                end
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge ck) begin
        if (reset) begin
            r_stop_q   <= 1'b0;
            r_match_q  <= 1'b0;
            r_sec_cnt  <= '0;
            r_tone_cnt <= '0;
            r_gate     <= 1'b0;
            r_tone     <= 1'b0;
        end else begin
            r_stop_q  <= stop;
            r_match_q <= match;

            if (w_restart) begin
                r_sec_cnt <= '0;
                r_gate    <= 1'b1;
            end else if (w_ring_tick) begin
                r_sec_cnt <= r_sec_cnt + SEC_W'(1);
                r_gate    <= ~r_gate;
            end
`ifdef ALARM_SNOOZE_EN
            else if (w_snooze_start) begin
                r_sec_cnt <= '0;
            end else if (w_snooze_tick) begin
                r_sec_cnt <= r_sec_cnt + SEC_W'(1);
            end
`endif

            // Tone divider free-runs only while ringing.
            if (w_restart) begin
                r_tone_cnt <= '0;
                r_tone     <= 1'b0;
            end else if (r_state == S_RING) begin
                if (r_tone_cnt == TONE_LAST) begin
                    r_tone_cnt <= '0;
                    r_tone     <= ~r_tone;
                end else begin
                    r_tone_cnt <= r_tone_cnt + TONE_W'(1);
                end
            end
        end
    end

`ifdef ALARM_SNOOZE_EN
    always_ff @(posedge ck) begin
        if (reset) begin
            r_snooze_q   <= 1'b0;
            r_snooze_cnt <= 2'd0;
        end else begin
            r_snooze_q <= snooze;
            if (!enable || w_ring_start)
                r_snooze_cnt <= 2'd0;
            else if (w_snooze_start)
                r_snooze_cnt <= r_snooze_cnt + 2'd1;
        end
    end
`endif

endmodule
